// File: rtl/pipe_stage_hs_reg_if.sv
// Handshake bundle for one generic pipeline stage: upstream valid/ready/data,
// downstream valid/ready/data, the flush strobe and the occupancy readout.
`timescale 1ns/1ps

interface pipe_stage_hs_reg_if #(
  parameter int DATA_W = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  // Producer/consumer side that drives the stage (upstream, downstream ready, flush)
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  // The stage itself
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_hs_reg.sv
// Generic pipeline-stage register with valid/ready handshake and flush.
// SKID=1 holds up to two bundles (main + skid) so in_ready comes straight from
// the state register; SKID=0 is a single register with combinational in_ready.
`timescale 1ns/1ps

module pipe_stage_hs_reg #(
  parameter int DATA_W     = 32,
  parameter int SKID       = 1,
  parameter int FLUSH_ZERO = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_stage_hs_reg_if.slave  bus
);

  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.occupancy = occupancy;

  if (SKID != 0) begin : g_skid

    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire;
    logic              out_fire;

    // Upstream only sees the registered state, so out_ready never reaches in_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = (state_q == FULL) ? 2'd2 :
                       (state_q == HALF) ? 2'd1 : 2'd0;
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;

    // State and data registers; reset drops everything held.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end

    // Next state: flush wins; otherwise main feeds the output and skid catches the stalled extra bundle.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (bus.flush) begin
        state_d = EMPTY;
        if (FLUSH_ZERO != 0) begin
          main_d = '0;
          skid_d = '0;
        end
      end else begin
        case (state_q)
          EMPTY: begin
            if (in_fire) begin
              state_d = HALF;
              main_d  = bus.in_data;
            end
          end
          HALF: begin
            if (in_fire && out_fire) begin
              main_d = bus.in_data;
            end else if (in_fire) begin
              state_d = FULL;
              skid_d  = bus.in_data;
            end else if (out_fire) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (out_fire) begin
              state_d = HALF;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end

  end else begin : g_single

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              in_fire;
    logic              out_fire;

    // A slot frees up in the same cycle the downstream takes the current bundle.
    assign in_ready  = !valid_q | bus.out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign occupancy = {1'b0, valid_q};
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = valid_q & bus.out_ready;

    // Single holding register; reset drops the held bundle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    // Next value: flush wins, then a new bundle, then plain drain.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (bus.flush) begin
        valid_d = 1'b0;
        if (FLUSH_ZERO != 0) begin
          data_d = '0;
        end
      end else if (in_fire) begin
        valid_d = 1'b1;
        data_d  = bus.in_data;
      end else if (out_fire) begin
        valid_d = 1'b0;
      end
    end

  end

endmodule

// File: tb/tb_pipe_stage_hs_reg.sv
// Self-checking bench: a 2-deep skid stage (32 bit) and a single-register
// stage (172 bit) run side by side against queue-based FIFO reference models.
`timescale 1ns/1ps

module tb_pipe_stage_hs_reg;

  localparam int W_A = 32;
  localparam int W_B = 172;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_hs_reg_if #(.DATA_W(W_A)) bus_a ();
  pipe_stage_hs_reg_if #(.DATA_W(W_B)) bus_b ();

  pipe_stage_hs_reg #(.DATA_W(W_A), .SKID(1), .FLUSH_ZERO(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  pipe_stage_hs_reg #(.DATA_W(W_B), .SKID(0), .FLUSH_ZERO(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: the stage is a FIFO of capacity 2 (a) or 1 (b)
  logic [W_B-1:0] q_a[$];
  logic [W_B-1:0] q_b[$];
  bit zero_a = 1'b1;
  bit zero_b = 1'b1;

  task automatic checkOutput(input string tag, input logic [W_B-1:0] observed,
                             input logic [W_B-1:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // One clock: compare outputs with the model on the falling edge, advance the model on the rising edge
  task automatic stepCycle();
    logic exp_va, exp_ra, in_fa, out_fa, fl_a;
    logic exp_vb, exp_rb, in_fb, out_fb, fl_b;
    logic [W_B-1:0] d_a, d_b;
    @(negedge clk);
    exp_va = (q_a.size() != 0);
    exp_ra = (q_a.size() < 2);
    checkOutput("a_out_valid", W_B'(bus_a.out_valid), W_B'(exp_va));
    checkOutput("a_in_ready", W_B'(bus_a.in_ready), W_B'(exp_ra));
    checkOutput("a_occupancy", W_B'(bus_a.occupancy), W_B'(q_a.size()));
    if (exp_va) checkOutput("a_out_data", W_B'(bus_a.out_data), q_a[0]);
    else if (zero_a) checkOutput("a_out_data_zero", W_B'(bus_a.out_data), {W_B{1'b0}});
    in_fa  = bus_a.in_valid && exp_ra;
    out_fa = exp_va && bus_a.out_ready;
    fl_a   = bus_a.flush;
    d_a    = W_B'(bus_a.in_data);

    exp_vb = (q_b.size() != 0);
    exp_rb = !exp_vb || bus_b.out_ready;
    checkOutput("b_out_valid", W_B'(bus_b.out_valid), W_B'(exp_vb));
    checkOutput("b_in_ready", W_B'(bus_b.in_ready), W_B'(exp_rb));
    checkOutput("b_occupancy", W_B'(bus_b.occupancy), W_B'(q_b.size()));
    if (exp_vb) checkOutput("b_out_data", bus_b.out_data, q_b[0]);
    else if (zero_b) checkOutput("b_out_data_zero", bus_b.out_data, {W_B{1'b0}});
    in_fb  = bus_b.in_valid && exp_rb;
    out_fb = exp_vb && bus_b.out_ready;
    fl_b   = bus_b.flush;
    d_b    = bus_b.in_data;

    @(posedge clk);
    if (out_fa) void'(q_a.pop_front());
    if (fl_a) begin
      q_a.delete();
      zero_a = 1'b1;
    end else if (in_fa) begin
      q_a.push_back(d_a);
      zero_a = 1'b0;
    end
    if (out_fb) void'(q_b.pop_front());
    if (fl_b) begin
      q_b.delete();
      zero_b = 1'b1;
    end else if (in_fb) begin
      q_b.push_back(d_b);
      zero_b = 1'b0;
    end
    #1;
  endtask

  task automatic applyStimulus(input logic av, input logic [W_A-1:0] ad, input logic ar,
                               input logic af, input logic bv, input logic [W_B-1:0] bd,
                               input logic br, input logic bf);
    bus_a.in_valid  = av;
    bus_a.in_data   = ad;
    bus_a.out_ready = ar;
    bus_a.flush     = af;
    bus_b.in_valid  = bv;
    bus_b.in_data   = bd;
    bus_b.out_ready = br;
    bus_b.flush     = bf;
    stepCycle();
  endtask

  // Pulse reset between clock edges and check that outputs react without a clock
  task automatic doReset();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_a_out_valid", W_B'(bus_a.out_valid), W_B'(1'b0));
    checkOutput("rst_a_occupancy", W_B'(bus_a.occupancy), W_B'(2'd0));
    checkOutput("rst_a_in_ready", W_B'(bus_a.in_ready), W_B'(1'b1));
    checkOutput("rst_a_out_data", W_B'(bus_a.out_data), {W_B{1'b0}});
    checkOutput("rst_b_out_valid", W_B'(bus_b.out_valid), W_B'(1'b0));
    checkOutput("rst_b_occupancy", W_B'(bus_b.occupancy), W_B'(2'd0));
    checkOutput("rst_b_out_data", bus_b.out_data, {W_B{1'b0}});
    q_a.delete();
    q_b.delete();
    zero_a = 1'b1;
    zero_b = 1'b1;
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [W_B-1:0] randWide();
    logic [191:0] tmp;
    tmp = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return tmp[W_B-1:0];
  endfunction

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0; bus_a.flush = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0; bus_b.flush = 1'b0;
    repeat (2) @(posedge clk);
    doReset();

    // Back-to-back stream 1..4
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, W_A'(i), 1'b1, 1'b0, 1'b1, W_B'(i), 1'b1, 1'b0);
      checkOutput("t1_a_data", W_B'(bus_a.out_data), W_B'(i));
      checkOutput("t1_a_occ", W_B'(bus_a.occupancy), W_B'(1));
      checkOutput("t1_a_in_ready", W_B'(bus_a.in_ready), W_B'(1'b1));
      checkOutput("t1_b_data", bus_b.out_data, W_B'(i));
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Backpressure: A then B with out_ready low
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, W_B'(32'hA), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, W_B'(32'hB), 1'b0, 1'b0);
    checkOutput("t2_occ_full", W_B'(bus_a.occupancy), W_B'(2));
    checkOutput("t2_in_ready_low", W_B'(bus_a.in_ready), W_B'(1'b0));
    checkOutput("t2_hold_a", W_B'(bus_a.out_data), W_B'(32'hA));
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("t2_hold_a_stable", W_B'(bus_a.out_data), W_B'(32'hA));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t2_then_b", W_B'(bus_a.out_data), W_B'(32'hB));
    checkOutput("t2_occ_one", W_B'(bus_a.occupancy), W_B'(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t2_occ_zero", W_B'(bus_a.occupancy), W_B'(0));

    // Flush while full, with C arriving the same cycle
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, W_B'(32'hA), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, W_B'(32'hB), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b1, 1'b1, W_B'(32'hC), 1'b0, 1'b1);
    checkOutput("t3_out_valid", W_B'(bus_a.out_valid), W_B'(1'b0));
    checkOutput("t3_occ", W_B'(bus_a.occupancy), W_B'(0));
    checkOutput("t3_in_ready", W_B'(bus_a.in_ready), W_B'(1'b1));
    checkOutput("t3_out_data", W_B'(bus_a.out_data), {W_B{1'b0}});
    checkOutput("t3_b_out_valid", W_B'(bus_b.out_valid), W_B'(1'b0));
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Flush coincident with delivery of A
    applyStimulus(1'b1, 32'hA4, 1'b0, 1'b0, 1'b1, W_B'(32'hA4), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("t4_no_dup_a", W_B'(bus_a.out_valid), W_B'(1'b0));
    checkOutput("t4_no_dup_b", W_B'(bus_b.out_valid), W_B'(1'b0));
    repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Reset mid-stream, then 0x55
    applyStimulus(1'b1, 32'h11, 1'b1, 1'b0, 1'b1, W_B'(32'h11), 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, W_B'(32'h22), 1'b0, 1'b0);
    doReset();
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b0, 1'b1, W_B'(32'h55), 1'b1, 1'b0);
    checkOutput("t5_a_55", W_B'(bus_a.out_data), W_B'(32'h55));
    checkOutput("t5_b_55", bus_b.out_data, W_B'(32'h55));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Wide single-register stage: continuous input, alternating out_ready
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, randWide(), (i % 2) == 0, 1'b0);
    end
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t6_drained", W_B'(bus_b.out_valid), W_B'(1'b0));

    // Random traffic on both stages with occasional flushes
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 16) == 0,
                    ($urandom % 4) != 0, randWide(), ($urandom % 3) != 0, ($urandom % 16) == 0);
    end
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
